// File: rtl/alu_writeback.sv
// ============================================================================
// Module   : alu_writeback
// Purpose  : ALU result stage, 4x8 register file and status register.
//            Provides bypassed operand reads and a branch-condition evaluator.
//            Optional ALU_WB_STICKY_V_EN: sticky overflow flag with CLR_V.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_writeback #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_f,
  input  logic       in_z,
  input  logic       in_c,
  input  logic       in_s,
  input  logic       in_v,
  input  logic       in_we,
  input  logic [1:0] in_waddr,
  input  logic       in_flag_we,
  input  logic       hold,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  input  logic       cond_req,
  input  logic [2:0] cond,
  output logic       cond_valid,
  output logic       cond_true,
  input  logic       clr_v,
  output logic [3:0] sr_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic       r_stg_valid;
  logic [7:0] r_stg_f;
  logic [3:0] r_stg_flags;   // {V,S,C,Z}
  logic       r_stg_we;
  logic [1:0] r_stg_waddr;
  logic       r_stg_flag_we;

  logic [7:0] r_rf [NREG];
  logic [3:0] r_sr;
  logic [2:0] r_cond;
  state_t     r_state;
  state_t     w_state_nxt;

  logic       w_capture;
  logic       w_commit;
  logic       w_cond_hit;

  assign in_ready  = !r_stg_valid || !hold;
  assign w_capture = in_valid && in_ready;
  assign w_commit  = r_stg_valid && !hold;

  // Stage register: reloads on capture, empties on commit without capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_valid   <= 1'b0;
      r_stg_f       <= 8'h00;
      r_stg_flags   <= 4'h0;
      r_stg_we      <= 1'b0;
      r_stg_waddr   <= 2'd0;
      r_stg_flag_we <= 1'b0;
    end else if (w_capture) begin
      r_stg_valid   <= 1'b1;
      r_stg_f       <= in_f;
      r_stg_flags   <= {in_v, in_s, in_c, in_z};
      r_stg_we      <= in_we;
      r_stg_waddr   <= in_waddr;
      r_stg_flag_we <= in_flag_we;
    end else if (w_commit) begin
      r_stg_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= 8'h00;
    end else if (w_commit && r_stg_we) begin
      r_rf[r_stg_waddr] <= r_stg_f;
    end
  end

`ifdef ALU_WB_STICKY_V_EN
  // V accumulates across flag writes; a clear wins over a simultaneous set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 4'h0;
    end else if (w_commit && r_stg_flag_we) begin
      r_sr <= {(r_sr[3] | r_stg_flags[3]) & ~clr_v, r_stg_flags[2:0]};
    end else if (clr_v) begin
      r_sr[3] <= 1'b0;
    end
  end
`else
  logic w_unused_clr_v;
  assign w_unused_clr_v = clr_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 4'h0;
    end else if (w_commit && r_stg_flag_we) begin
      r_sr <= r_stg_flags;
    end
  end
`endif

  assign sr_out = r_sr;

  assign a_out = (r_stg_valid && r_stg_we && r_stg_waddr == ra) ? r_stg_f : r_rf[ra];
  assign b_out = (r_stg_valid && r_stg_we && r_stg_waddr == rb) ? r_stg_f : r_rf[rb];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cond  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && cond_req) r_cond <= cond;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (cond_req) w_state_nxt = (r_stg_valid || w_capture) ? S_WAIT : S_RESP;
      S_WAIT: if (!r_stg_valid) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cond_hit = 1'b0;
    case (r_cond)
      3'b000: w_cond_hit = 1'b1;
      3'b001: w_cond_hit = r_sr[0];
      3'b010: w_cond_hit = !r_sr[0];
      3'b011: w_cond_hit = r_sr[1];
      3'b100: w_cond_hit = !r_sr[1];
      3'b101: w_cond_hit = r_sr[2];
      3'b110: w_cond_hit = r_sr[3];
      3'b111: w_cond_hit = !r_sr[3];
      default: w_cond_hit = 1'b0;
    endcase
  end

  assign cond_valid = (r_state == S_RESP);
  assign cond_true  = (r_state == S_RESP) && w_cond_hit;

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
// ============================================================================
// Module   : tb_alu_writeback
// Purpose  : Directed self-checking bench for alu_writeback.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_writeback;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_f;
  logic       in_z, in_c, in_s, in_v;
  logic       in_we;
  logic [1:0] in_waddr;
  logic       in_flag_we;
  logic       hold;
  logic [1:0] ra, rb;
  logic [7:0] a_out, b_out;
  logic       cond_req;
  logic [2:0] cond;
  logic       cond_valid;
  logic       cond_true;
  logic       clr_v;
  logic [3:0] sr_out;

  int n_checks;
  int n_fail;

  alu_writeback #(.NREG(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_f       (in_f),
    .in_z       (in_z),
    .in_c       (in_c),
    .in_s       (in_s),
    .in_v       (in_v),
    .in_we      (in_we),
    .in_waddr   (in_waddr),
    .in_flag_we (in_flag_we),
    .hold       (hold),
    .ra         (ra),
    .rb         (rb),
    .a_out      (a_out),
    .b_out      (b_out),
    .cond_req   (cond_req),
    .cond       (cond),
    .cond_valid (cond_valid),
    .cond_true  (cond_true),
    .clr_v      (clr_v),
    .sr_out     (sr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_f = 8'h00;
    in_z = 1'b0; in_c = 1'b0; in_s = 1'b0; in_v = 1'b0;
    in_we = 1'b0; in_waddr = 2'd0; in_flag_we = 1'b0; hold = 1'b0;
    ra = 2'd0; rb = 2'd0; cond_req = 1'b0; cond = 3'd0; clr_v = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_sr", sr_out, 0);
    chk("rst_cv", cond_valid, 0);
    chk("rst_ct", cond_true, 0);
    rst_n = 1'b1;
    step();

    // Write 0x5A to R2 with C=1
    in_valid = 1; in_f = 8'h5A; in_we = 1; in_waddr = 2; in_flag_we = 1;
    in_c = 1; ra = 2; rb = 0;
    step();
    in_valid = 0; in_c = 0;
    #1;
    chk("t1_bypass_a", a_out, 8'h5A);
    chk("t1_ready", in_ready, 1);
    chk("t1_sr_pre", sr_out, 4'h0);
    step();
    chk("t1_sr", sr_out, 4'b0010);
    chk("t1_a_rf", a_out, 8'h5A);
    chk("t1_b", b_out, 8'h00);
    rb = 2;
    #1;
    chk("t1_b_rf", b_out, 8'h5A);

    // Back-to-back writes to R1 with hold
    in_valid = 1; in_f = 8'h11; in_we = 1; in_waddr = 1; in_flag_we = 0; ra = 1;
    step();
    hold = 1; in_f = 8'h22;
    #1;
    chk("t2_ready_hold", in_ready, 0);
    chk("t2_bypass11", a_out, 8'h11);
    step();
    chk("t2_ready_hold2", in_ready, 0);
    chk("t2_bypass11b", a_out, 8'h11);
    chk("t2_r2_intact", b_out, 8'h5A);
    hold = 0;
    #1;
    chk("t2_ready_rel", in_ready, 1);
    step();
    in_valid = 0;
    #1;
    chk("t2_bypass22", a_out, 8'h22);
    step();
    chk("t2_rf22", a_out, 8'h22);
    chk("t2_ready", in_ready, 1);

    // Condition request together with capture (Z=1) -> waits for commit
    in_valid = 1; in_f = 8'h00; in_we = 0; in_flag_we = 1;
    in_z = 1; in_c = 0; in_s = 0; in_v = 0;
    cond_req = 1; cond = 3'b001;
    step();
    in_valid = 0; cond_req = 0; in_z = 0;
    chk("t3_wait_cv0", cond_valid, 0);
    step();
    chk("t3_wait_cv1", cond_valid, 0);
    chk("t3_sr_z", sr_out, 4'b0001);
    step();
    chk("t3_cv", cond_valid, 1);
    chk("t3_ct", cond_true, 1);
    step();
    chk("t3_cv_drop", cond_valid, 0);
    cond_req = 1; cond = 3'b000;
    step();
    cond_req = 0;
    chk("t3_idle_cv", cond_valid, 1);
    chk("t3_idle_ct", cond_true, 1);
    step();
    cond_req = 1; cond = 3'b010;
    step();
    cond_req = 0;
    chk("t3_nz_cv", cond_valid, 1);
    chk("t3_nz_ct", cond_true, 0);

    // V=1 then V=0, then CLR_V
    in_valid = 1; in_we = 0; in_flag_we = 1; in_v = 1;
    step();
    in_v = 0;
    step();
    in_valid = 0;
    chk("t4_sr_v1", sr_out, 4'b1000);
    step();
`ifdef ALU_WB_STICKY_V_EN
    chk("t4_sr_v_sticky", sr_out, 4'b1000);
`else
    chk("t4_sr_v_plain", sr_out, 4'b0000);
`endif
    clr_v = 1;
    step();
    clr_v = 0;
    chk("t4_sr_clr", sr_out, 4'b0000);

    // Flag-only write: S=1, registers untouched
    in_valid = 1; in_f = 8'h80; in_we = 0; in_waddr = 0; in_flag_we = 1; in_s = 1;
    ra = 0; rb = 3;
    step();
    in_valid = 0; in_s = 0;
    chk("t5_no_bypass", a_out, 8'h00);
    step();
    chk("t5_sr_s", sr_out, 4'b0100);
    chk("t5_r0", a_out, 8'h00);
    chk("t5_r3", b_out, 8'h00);
    ra = 2;
    #1;
    chk("t5_r2", a_out, 8'h5A);
    cond_req = 1; cond = 3'b101;
    step();
    cond_req = 0;
    chk("t5_cv", cond_valid, 1);
    chk("t5_ct", cond_true, 1);

    // Reset while stage full under hold and FSM waiting
    hold = 1; in_valid = 1; in_f = 8'h77; in_we = 1; in_waddr = 3; in_flag_we = 1;
    in_z = 1; ra = 3;
    step();
    in_valid = 0; in_z = 0; cond_req = 1; cond = 3'b000;
    #1;
    chk("t6_bypass77", a_out, 8'h77);
    chk("t6_ready0", in_ready, 0);
    step();
    cond_req = 0;
    rst_n = 0;
    #1;
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_a", a_out, 8'h00);
    chk("t6_rst_sr", sr_out, 4'h0);
    chk("t6_rst_cv", cond_valid, 0);
    #2;
    rst_n = 1; hold = 0;
    step();
    chk("t6_no_commit", a_out, 8'h00);
    chk("t6_sr_after", sr_out, 4'h0);
    chk("t6_cv_a", cond_valid, 0);
    step();
    chk("t6_cv_b", cond_valid, 0);
    ra = 2;
    #1;
    chk("t6_r2_cleared", a_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
